// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// A queue entry carries the fetched word together with its PC+4.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  localparam int unsigned ENTRY_W         = 64;
  localparam int unsigned ENTRY_INSTR_LSB = 32;
  localparam int unsigned ENTRY_PC4_LSB   = 0;

  typedef logic [ENTRY_W-1:0] fq_entry_t;

  function automatic fq_entry_t pack_entry(input logic [31:0] instr, input logic [31:0] pc_plus4);
    return {instr, pc_plus4};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory request/response, redirect and decode-side handshake of the fetch queue.
// master is the fetch queue itself; slave is the surrounding memory/decode logic.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction queue; head is read straight from registered storage.
// Flush empties the queue by snapping rd_ptr onto wr_ptr.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fq_entry_t              i_wdata,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fq_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam fq_entry_t RESET_ENTRY = {INSTR_NOP, 32'h0000_0000};

  fq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_d;

  always_comb begin
    w_count_d = r_count + CW'(i_push) - CW'(i_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_mem    <= '{default: RESET_ENTRY};
    end else if (i_flush) begin
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_d;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: credit-limited in-order word fetch, response queue, and
// redirect handling that flushes the queue and drops responses still in flight.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [31:0]   w_fetch_pc_d;
  logic [31:0]   w_resp_pc_d;
  logic [CW-1:0] w_outstanding_d;
  logic [CW-1:0] w_drop_d;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_resp_dec;
  logic [31:0]   w_redirect_pc;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  fq_entry_t     w_wdata;
  fq_entry_t     w_head;

  // Queue entries plus outstanding requests never exceed DEPTH, so a
  // response always finds a free slot.
  assign w_inflight    = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_req_valid   = !rst && !bus.redirect_valid && (w_inflight < DEPTH_W);
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;
  assign w_resp_dec    = CW'(bus.imem_resp_valid);
  assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  assign w_out_valid = (w_count != '0);
  assign w_push      = bus.imem_resp_valid && (r_drop == '0) && !bus.redirect_valid;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.redirect_valid;
  assign w_wdata     = pack_entry(bus.imem_resp_data, r_resp_pc + 32'd4);

  always_comb begin
    w_fetch_pc_d    = r_fetch_pc;
    w_resp_pc_d     = r_resp_pc;
    w_outstanding_d = r_outstanding;
    w_drop_d        = r_drop;
    if (bus.redirect_valid) begin
      // A response landing in the redirect cycle is already discarded here.
      w_fetch_pc_d    = w_redirect_pc;
      w_resp_pc_d     = w_redirect_pc;
      w_outstanding_d = r_outstanding - w_resp_dec;
      w_drop_d        = r_outstanding - w_resp_dec;
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_d = r_fetch_pc + 32'd4;
      end
      w_outstanding_d = r_outstanding + CW'(w_req_fire) - w_resp_dec;
      if (bus.imem_resp_valid) begin
        if (r_drop != '0) begin
          w_drop_d = r_drop - CW'(1);
        end else begin
          w_resp_pc_d = r_resp_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_d;
      r_resp_pc     <= w_resp_pc_d;
      r_outstanding <= w_outstanding_d;
      r_drop        <= w_drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_instr      = w_head[ENTRY_INSTR_LSB +: 32];
  assign bus.out_pc_plus4   = w_head[ENTRY_PC4_LSB +: 32];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table for steady streaming,
// then hand-written sequences against a fixed-latency memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if fq ();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fq)
  );

  typedef struct {
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_out_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs [9];

  int n_pass  = 0;
  int n_total = 0;
  int cyc;
  int mem_lat;
  int req_total;
  logic mem_ready_en;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] pop_instr [$];
  logic [31:0] pop_pc4   [$];

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_out_valid;
  logic [31:0] s_out_instr;
  logic [31:0] s_out_pc4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sample();
    s_req_valid = fq.imem_req_valid;
    s_req_addr  = fq.imem_req_addr;
    s_out_valid = fq.out_valid;
    s_out_instr = fq.out_instr;
    s_out_pc4   = fq.out_pc_plus4;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    fq.imem_req_ready  = 1'b0;
    fq.imem_resp_valid = 1'b0;
    fq.imem_resp_data  = 32'h0;
    fq.redirect_valid  = 1'b0;
    fq.redirect_pc     = 32'h0;
    fq.out_ready       = 1'b0;
    @(posedge clk);
    #1;
    sample();
    check("rst req_valid", 32'(s_req_valid), 32'd0);
    check("rst req_addr", s_req_addr, 32'h0);
    check("rst out_valid", 32'(s_out_valid), 32'd0);
    check("rst out_instr", s_out_instr, 32'h0);
    check("rst out_pc_plus4", s_out_pc4, 32'h0);
    rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    pop_instr.delete();
    pop_pc4.delete();
    cyc       = 1;
    req_total = 0;
  endtask

  // Entered just after a rising edge; drives the memory, samples at the falling edge.
  task automatic run_cycle();
    fq.imem_req_ready = mem_ready_en;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      fq.imem_resp_valid = 1'b1;
      fq.imem_resp_data  = word_at(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      fq.imem_resp_valid = 1'b0;
      fq.imem_resp_data  = 32'h0;
    end
    #4;
    sample();
    if (s_req_valid && fq.imem_req_ready) begin
      pend_addr.push_back(s_req_addr);
      pend_due.push_back(cyc + mem_lat);
      req_total++;
    end
    if (s_out_valid && fq.out_ready) begin
      pop_instr.push_back(s_out_instr);
      pop_pc4.push_back(s_out_pc4);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pop_instr.size() < n && k < budget) begin
      run_cycle();
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req_ready resp_valid resp_data out_ready | req_valid req_addr out_valid instr pc4
    vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00};
    vecs[1] = '{1'b1, 1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,         32'h00};
    vecs[2] = '{1'b1, 1'b1, 32'hDEAD_0004, 1'b1, 1'b1, 32'h08, 1'b1, 32'hDEAD_0000, 32'h04};
    vecs[3] = '{1'b1, 1'b1, 32'hDEAD_0008, 1'b1, 1'b1, 32'h0C, 1'b1, 32'hDEAD_0004, 32'h08};
    vecs[4] = '{1'b1, 1'b1, 32'hDEAD_000C, 1'b1, 1'b1, 32'h10, 1'b1, 32'hDEAD_0008, 32'h0C};
    vecs[5] = '{1'b0, 1'b1, 32'hDEAD_0010, 1'b0, 1'b1, 32'h14, 1'b1, 32'hDEAD_000C, 32'h10};
    vecs[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14, 1'b1, 32'hDEAD_000C, 32'h10};
    vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14, 1'b1, 32'hDEAD_0010, 32'h14};
    vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14, 1'b0, 32'h0,         32'h00};

    mem_lat      = 1;
    mem_ready_en = 1'b0;

    // Streaming with a 1-cycle memory, then a backpressure/drain tail.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fq.imem_req_ready  = vecs[i].req_ready;
      fq.imem_resp_valid = vecs[i].resp_valid;
      fq.imem_resp_data  = vecs[i].resp_data;
      fq.out_ready       = vecs[i].out_ready;
      #4;
      check($sformatf("vec%0d req_valid", i), 32'(fq.imem_req_valid), 32'(vecs[i].exp_req_valid));
      check($sformatf("vec%0d req_addr", i), fq.imem_req_addr, vecs[i].exp_req_addr);
      check($sformatf("vec%0d out_valid", i), 32'(fq.out_valid), 32'(vecs[i].exp_out_valid));
      if (vecs[i].exp_out_valid) begin
        check($sformatf("vec%0d out_instr", i), fq.out_instr, vecs[i].exp_instr);
        check($sformatf("vec%0d out_pc_plus4", i), fq.out_pc_plus4, vecs[i].exp_pc4);
      end
      @(posedge clk);
      #1;
    end

    // Memory not ready for 5 cycles: request holds at the reset PC.
    do_reset();
    mem_lat      = 1;
    mem_ready_en = 1'b0;
    fq.out_ready = 1'b1;
    repeat (5) begin
      run_cycle();
      check("stall req_valid", 32'(s_req_valid), 32'd1);
      check("stall req_addr", s_req_addr, 32'h0);
      check("stall out_valid", 32'(s_out_valid), 32'd0);
    end
    mem_ready_en = 1'b1;
    run_cycle();
    check("stall release addr", s_req_addr, 32'h0);
    check("stall release count", 32'(req_total), 32'd1);

    // Decode stalled, 3-cycle memory: credits cap requests at DEPTH.
    do_reset();
    mem_lat      = 3;
    mem_ready_en = 1'b1;
    fq.out_ready = 1'b0;
    repeat (10) run_cycle();
    check("fill req_total", 32'(req_total), 32'd4);
    check("fill req_valid", 32'(s_req_valid), 32'd0);
    check("fill out_valid", 32'(s_out_valid), 32'd1);
    check("fill out_instr", s_out_instr, word_at(32'h0));
    check("fill out_pc_plus4", s_out_pc4, 32'h4);
    fq.out_ready = 1'b1;
    run_cycle();
    fq.out_ready = 1'b0;
    repeat (6) run_cycle();
    check("refill req_total", 32'(req_total), 32'd5);
    check("refill req_valid", 32'(s_req_valid), 32'd0);
    check("refill head", s_out_instr, word_at(32'h4));

    // Redirect with two requests outstanding: both responses dropped.
    do_reset();
    mem_lat      = 3;
    mem_ready_en = 1'b1;
    fq.out_ready = 1'b1;
    run_cycle();
    run_cycle();
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'h0000_0100;
    run_cycle();
    check("redir req suppressed", 32'(s_req_valid), 32'd0);
    fq.redirect_valid = 1'b0;
    run_cycle();
    check("redir out_valid", 32'(s_out_valid), 32'd0);
    check("redir req_valid", 32'(s_req_valid), 32'd1);
    check("redir req_addr", s_req_addr, 32'h100);
    wait_pops(1, 20);
    check("redir pop seen", 32'(pop_instr.size() >= 1), 32'd1);
    if (pop_instr.size() >= 1) begin
      check("redir first instr", pop_instr[0], word_at(32'h100));
      check("redir first pc_plus4", pop_pc4[0], 32'h104);
    end

    // Redirect coinciding with a response and a pop.
    do_reset();
    mem_lat      = 1;
    mem_ready_en = 1'b1;
    fq.out_ready = 1'b1;
    run_cycle();
    run_cycle();
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'h0000_0100;
    run_cycle();
    check("coinc out_valid", 32'(s_out_valid), 32'd1);
    check("coinc out_instr", s_out_instr, word_at(32'h0));
    fq.redirect_valid = 1'b0;
    pop_instr.delete();
    pop_pc4.delete();
    run_cycle();
    check("coinc next out_valid", 32'(s_out_valid), 32'd0);
    check("coinc next req_valid", 32'(s_req_valid), 32'd1);
    check("coinc next req_addr", s_req_addr, 32'h100);
    wait_pops(1, 20);
    check("coinc pop seen", 32'(pop_instr.size() >= 1), 32'd1);
    if (pop_instr.size() >= 1) begin
      check("coinc first instr", pop_instr[0], word_at(32'h100));
      check("coinc first pc_plus4", pop_pc4[0], 32'h104);
    end

    // PC wrap at the top of the address space; low redirect bits ignored.
    do_reset();
    mem_lat      = 1;
    mem_ready_en = 1'b1;
    fq.out_ready = 1'b1;
    run_cycle();
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = 32'hFFFF_FFFE;
    run_cycle();
    fq.redirect_valid = 1'b0;
    pop_instr.delete();
    pop_pc4.delete();
    run_cycle();
    check("wrap req_addr hi", s_req_addr, 32'hFFFF_FFFC);
    run_cycle();
    check("wrap req_addr lo", s_req_addr, 32'h0000_0000);
    wait_pops(2, 20);
    check("wrap pops seen", 32'(pop_instr.size() >= 2), 32'd1);
    if (pop_instr.size() >= 2) begin
      check("wrap instr0", pop_instr[0], word_at(32'hFFFF_FFFC));
      check("wrap pc_plus4_0", pop_pc4[0], 32'h0000_0000);
      check("wrap instr1", pop_instr[1], word_at(32'h0000_0000));
      check("wrap pc_plus4_1", pop_pc4[1], 32'h0000_0004);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
